// File: rtl/sensor_height_acq_pkg.sv
// Shared types and constants for the sensor height acquisition stage.
// Define ROUND_EN to make every division round half up instead of truncating.
package sensor_height_pkg;
    localparam int SENSOR_W = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_e;

`ifdef ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    // Half-LSB terms added ahead of the >>1 and >>2 pair/quad averages.
    localparam logic [1:0] RND2 = {1'b0, ROUND};
    localparam logic [1:0] RND4 = {ROUND, 1'b0};

    function automatic int acc_w(input int samples);
        return SENSOR_W + $clog2(samples);
    endfunction

    function automatic int final_rnd(input int samples);
        return (ROUND && samples > 1) ? samples / 2 : 0;
    endfunction
endpackage

// File: rtl/sensor_height_acq_if.sv
// Frame-in / height-out handshake bundle of sensor_height_acq.
interface sensor_height_if;
    logic [7:0] sensor1;
    logic [7:0] sensor2;
    logic [7:0] sensor3;
    logic [7:0] sensor4;
    logic       in_valid;
    logic       in_ready;
    logic       frame_err;
    logic [7:0] height;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  sensor1, sensor2, sensor3, sensor4, in_valid, out_ready,
        output in_ready, frame_err, height, out_valid
    );

    modport master (
        output sensor1, sensor2, sensor3, sensor4, in_valid, out_ready,
        input  in_ready, frame_err, height, out_valid
    );
endinterface

// File: rtl/sensor_height_acq_pair_select.sv
// Per-frame pair validity check and frame average (combinational).
// Rounding of the averages follows ROUND_EN through the package constants.
module sensor_pair_select
    import sensor_height_pkg::*;
(
    input  logic [SENSOR_W-1:0] s1_i,
    input  logic [SENSOR_W-1:0] s2_i,
    input  logic [SENSOR_W-1:0] s3_i,
    input  logic [SENSOR_W-1:0] s4_i,
    output logic [SENSOR_W-1:0] frame_height_o,
    output logic                frame_ok_o
);
    localparam int W2 = SENSOR_W + 1;
    localparam int W4 = SENSOR_W + 2;

    logic          z13, z24;
    logic [W2-1:0] sum13, sum24;
    logic [W4-1:0] sum4;

    // A pair is failed when either of its sensors reads zero.
    assign z13   = (s1_i == '0) || (s3_i == '0);
    assign z24   = (s2_i == '0) || (s4_i == '0);
    assign sum13 = W2'(s1_i) + W2'(s3_i) + W2'(RND2);
    assign sum24 = W2'(s2_i) + W2'(s4_i) + W2'(RND2);
    assign sum4  = W4'(s1_i) + W4'(s2_i) + W4'(s3_i) + W4'(s4_i) + W4'(RND4);

    always_comb begin
        frame_ok_o     = 1'b1;
        frame_height_o = SENSOR_W'(sum4 >> 2);
        if (z13 && !z24) begin
            frame_height_o = SENSOR_W'(sum24 >> 1);
        end else if (z24 && !z13) begin
            frame_height_o = SENSOR_W'(sum13 >> 1);
        end else if (z13 && z24) begin
            frame_ok_o     = 1'b0;
            frame_height_o = '0;
        end
    end
endmodule

// File: rtl/sensor_height_acq.sv
// Averages SAMPLES valid sensor frames into one height for the square-root stage.
// ROUND_EN (via the package) selects round-half-up for the final division.
module sensor_height_acq
    import sensor_height_pkg::*;
#(
    parameter int SAMPLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    sensor_height_if.slave bus
);
    localparam int SHIFT = $clog2(SAMPLES);
    localparam int ACC_W = acc_w(SAMPLES);
    localparam int CNT_W = $clog2(SAMPLES + 1);
    localparam logic [ACC_W-1:0] FIN_RND = ACC_W'(final_rnd(SAMPLES));

    state_e              state_q;
    logic [ACC_W-1:0]    acc_q, acc_d, rounded;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SENSOR_W-1:0] height_q;
    logic                frame_err_q, out_valid_q;
    logic [SENSOR_W-1:0] frame_h;
    logic                frame_ok;

    sensor_pair_select u_sel (
        .s1_i           (bus.sensor1),
        .s2_i           (bus.sensor2),
        .s3_i           (bus.sensor3),
        .s4_i           (bus.sensor4),
        .frame_height_o (frame_h),
        .frame_ok_o     (frame_ok)
    );

    assign acc_d   = acc_q + ACC_W'(frame_h);
    assign cnt_d   = cnt_q + CNT_W'(1);
    assign rounded = acc_q + FIN_RND;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            height_q    <= '0;
            frame_err_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                // in_ready is implied in these two states
                IDLE, ACCUM: if (bus.in_valid) begin
                    if (!frame_ok) begin
                        frame_err_q <= 1'b1;
                    end else begin
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_d;
                        state_q <= (cnt_d == CNT_W'(SAMPLES)) ? DIV : ACCUM;
                    end
                end
                DIV: begin
                    height_q    <= SENSOR_W'(rounded >> SHIFT);
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign bus.frame_err = frame_err_q;
    assign bus.height    = height_q;
    assign bus.out_valid = out_valid_q;
endmodule
